// File: rtl/msg_pkg.sv
// Shared types and constants for the message sequencer and its bench.
package msg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_SEND     = 3'd3,
        ST_FINISH   = 3'd4
    } state_e;

    localparam int MSG_LEN_DEFAULT = 12;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_X    = 8'h78;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_CR   = 8'h0D;

endpackage

// File: rtl/msg_sequencer.sv
// Wishbone read master that walks the character memory and feeds each byte
// to a UART transmitter over a strobe/busy handshake.
module msg_sequencer
    import msg_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT,
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    input  logic          i_wb_stall,
    input  logic          i_wb_ack,
    input  logic [DW-1:0] i_wb_data,
    output logic          o_tx_stb,
    output logic [DW-1:0] o_tx_data,
    input  logic          i_tx_busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(MSG_LEN - 1);
    localparam logic [7:0]    TMO_LIMIT = 8'(TIMEOUT);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    tmo_q, tmo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          tx_stb_q, tx_stb_d;
    logic [DW-1:0] tx_data_q, tx_data_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tmo_d     = tmo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        tx_stb_d  = tx_stb_q;
        tx_data_d = tx_data_q;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (i_start) begin
                    state_d = ST_REQ;
                    addr_d  = '0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            ST_REQ: begin
                if (!i_wb_stall) begin
                    stb_d = 1'b0;
                    tmo_d = '0;
                    // A zero-latency slave may ack in the accepting cycle itself.
                    if (i_wb_ack) begin
                        tx_data_d = i_wb_data;
                        tx_stb_d  = 1'b1;
                        cyc_d     = 1'b0;
                        state_d   = ST_SEND;
                    end else begin
                        state_d = ST_WAIT_ACK;
                    end
                end
            end

            ST_WAIT_ACK: begin
                if (i_wb_ack) begin
                    tx_data_d = i_wb_data;
                    tx_stb_d  = 1'b1;
                    cyc_d     = 1'b0;
                    state_d   = ST_SEND;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    // busy stays up through the err cycle and drops in IDLE.
                    if (tmo_d == TMO_LIMIT) begin
                        cyc_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_SEND: begin
                if (!i_tx_busy) begin
                    tx_stb_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end

            ST_FINISH: begin
                busy_d  = 1'b0;
                addr_d  = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            tx_stb_q  <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            tx_stb_q  <= tx_stb_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = 1'b0;
    assign o_wb_addr = addr_q;
    assign o_tx_stb  = tx_stb_q;
    assign o_tx_data = tx_data_q;

    a_stb_in_cyc: assert property (@(posedge i_clk) disable iff (i_reset) stb_q |-> cyc_q);
    a_tx_vs_bus:  assert property (@(posedge i_clk) disable iff (i_reset) !(tx_stb_q && cyc_q));

endmodule

// File: tb/tb_msg_sequencer.sv
// Scoreboard bench: memory/UART models drive the sequencer, expected bytes are
// queued at start time and popped by a monitor on every UART transfer.
module tb_msg_sequencer;
    import msg_pkg::*;

    localparam int MSG_LEN = 12;
    localparam int AW      = 5;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          o_busy, o_done, o_err;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic          wb_stall = 1'b0;
    logic          wb_ack = 1'b0;
    logic [DW-1:0] wb_data = '0;
    logic          o_tx_stb;
    logic [DW-1:0] o_tx_data;
    logic          tx_busy = 1'b0;

    msg_sequencer #(
        .MSG_LEN(MSG_LEN), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .i_wb_stall(wb_stall), .i_wb_ack(wb_ack),
        .i_wb_data(wb_data), .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data),
        .i_tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int exp_done = 0;
    int exp_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem [32];

    // Environment knobs
    int busy_mode = 0;      // 0 always ready, 1 busy 5 cycles per char, 2 random
    int stall_addr = -1;
    int stall_len = 0;
    bit rand_stall = 1'b0;
    int max_ack_dly = 0;
    int noack_addr = -1;
    bit stray_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory slave and UART busy model; drive just after each rising edge.
    bit       pend = 1'b0;
    int       pend_dly = 0;
    int       pend_addr = 0;
    bit       req_seen = 1'b0;
    int       stall_left = 0;
    bit       tx_seen = 1'b0;
    int       busy_left = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            wb_stall = 1'b0;
            wb_ack   = 1'b0;
            wb_data  = DW'($urandom);
            if (rst) begin
                pend = 1'b0; req_seen = 1'b0; stall_left = 0;
                tx_seen = 1'b0; busy_left = 0; tx_busy = 1'b0;
            end else begin
                if (pend) begin
                    if (pend_dly == 0) begin
                        wb_ack  = 1'b1;
                        wb_data = mem[pend_addr];
                        pend    = 1'b0;
                    end else begin
                        pend_dly--;
                    end
                end else if (o_wb_stb) begin
                    if (!req_seen) begin
                        req_seen = 1'b1;
                        if (int'(o_wb_addr) == stall_addr) stall_left = stall_len;
                        else stall_left = rand_stall ? int'($urandom_range(0, 2)) : 0;
                    end
                    if (stall_left > 0) begin
                        wb_stall = 1'b1;
                        stall_left--;
                    end else begin
                        req_seen = 1'b0;
                        if (int'(o_wb_addr) != noack_addr) begin
                            int d;
                            d = int'($urandom_range(0, max_ack_dly));
                            if (d == 0) begin
                                wb_ack  = 1'b1;
                                wb_data = mem[o_wb_addr];
                            end else begin
                                pend      = 1'b1;
                                pend_addr = int'(o_wb_addr);
                                pend_dly  = d - 1;
                            end
                        end
                    end
                end else begin
                    if (rand_stall) wb_stall = 1'($urandom % 2);
                    if (stray_ack && !o_wb_cyc && ($urandom % 4 == 0)) wb_ack = 1'b1;
                end

                if (busy_mode == 0) begin
                    tx_busy = 1'b0;
                end else if (busy_mode == 1) begin
                    if (o_tx_stb) begin
                        if (!tx_seen) begin
                            tx_seen = 1'b1;
                            busy_left = 5;
                        end
                        if (busy_left > 0) begin
                            tx_busy = 1'b1;
                            busy_left--;
                        end else begin
                            tx_busy = 1'b0;
                            tx_seen = 1'b0;
                        end
                    end else begin
                        tx_busy = 1'b0;
                    end
                end else begin
                    tx_busy = 1'($urandom % 2);
                end
            end
        end
    end

    // Monitor: compare UART transfers against the queue and track pulses.
    logic       prev_stb = 1'b0;
    logic [7:0] prev_data = '0;
    int         stb_run = 0;
    int         stb_run_addr = 0;
    int         wait_run = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stb = 1'b0; stb_run = 0; wait_run = 0;
            end else begin
                if (o_tx_stb && !tx_busy) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL extra_char: got %0h expected none at %0t", o_tx_data, $time);
                    end else begin
                        check("tx_char", o_tx_data, exp_q.pop_front());
                    end
                end
                if (o_tx_stb && prev_stb) check("tx_data_stable", o_tx_data, prev_data);
                check("stb_implies_cyc", o_wb_stb && !o_wb_cyc, 0);
                check("tx_stb_vs_cyc", o_tx_stb && o_wb_cyc, 0);
                if (o_done) done_cnt++;
                if (o_err) begin
                    err_cnt++;
                    check("timeout_cycles", wait_run, TIMEOUT);
                end
                if (o_wb_cyc && !o_wb_stb) wait_run++;
                else wait_run = 0;
                if (o_wb_stb) begin
                    stb_run++;
                    stb_run_addr = int'(o_wb_addr);
                end else begin
                    if (stb_run > 0 && stall_addr >= 0 && stb_run_addr == stall_addr)
                        check("stall_stb_cycles", stb_run, stall_len + 1);
                    stb_run = 0;
                end
                prev_stb  = o_tx_stb;
                prev_data = o_tx_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push_mem(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, o_busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic start_and_check();
        start_pulse();
        check("busy_after_start", o_busy, 1);
        check("addr_after_start", o_wb_addr, 0);
        check("stb_after_start", o_wb_stb, 1);
    endtask

    task automatic end_checks(input string name);
        check({name, "_done_cnt"}, done_cnt, exp_done);
        check({name, "_err_cnt"}, err_cnt, exp_err);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic load_hex_msg(input string s);
        mem[0] = CH_ZERO;
        mem[1] = CH_X;
        for (int i = 0; i < 8; i++) mem[2 + i] = s[i];
        mem[10] = CH_LF;
        mem[11] = CH_CR;
    endtask

    initial begin
        logic [7:0] golden [12];
        int n;
        bit seen;
        golden = '{8'h30, 8'h78, 8'h44, 8'h45, 8'h41, 8'h44,
                   8'h42, 8'h45, 8'h45, 8'h46, 8'h0A, 8'h0D};
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);

        #1 rst = 1'b1;
        #20;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_cyc", o_wb_cyc, 0);
        check("rst_stb", o_wb_stb, 0);
        check("rst_we", o_wb_we, 0);
        check("rst_addr", o_wb_addr, 0);
        check("rst_tx_stb", o_tx_stb, 0);
        check("rst_tx_data", o_tx_data, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);

        // DEADBEEF with an always-ready UART
        load_hex_msg("DEADBEEF");
        for (int i = 0; i < 12; i++) exp_q.push_back(golden[i]);
        exp_done++;
        start_and_check();
        wait_idle("t1_idle");
        end_checks("t1");

        // UART busy 5 cycles per character
        busy_mode = 1;
        for (int i = 0; i < 12; i++) exp_q.push_back(golden[i]);
        exp_done++;
        start_and_check();
        wait_idle("t2_idle");
        end_checks("t2");
        busy_mode = 0;

        // Slave stalls address 4 for 3 cycles
        stall_addr = 4;
        stall_len  = 3;
        push_mem(MSG_LEN);
        exp_done++;
        start_and_check();
        wait_idle("t3_idle");
        end_checks("t3");
        stall_addr = -1;

        // Address 2 never acked: timeout, then a clean restart
        noack_addr = 2;
        max_ack_dly = 2;
        push_mem(2);
        exp_err++;
        start_and_check();
        wait_idle("t4_idle");
        end_checks("t4");
        noack_addr = -1;
        push_mem(MSG_LEN);
        exp_done++;
        start_and_check();
        wait_idle("t4b_idle");
        end_checks("t4b");

        // Second start mid-message is ignored
        push_mem(MSG_LEN);
        exp_done++;
        start_and_check();
        repeat (10) @(negedge clk);
        start_pulse();
        check("busy_mid_msg", o_busy, 1);
        wait_idle("t5_idle");
        end_checks("t5");

        // Async reset while waiting on address 7
        noack_addr = 7;
        push_mem(7);
        start_and_check();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            seen = o_wb_cyc && !o_wb_stb && (o_wb_addr == 5'd7);
        end
        check("reach_wait_addr7", seen, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cyc", o_wb_cyc, 0);
        check("async_rst_tx_stb", o_tx_stb, 0);
        check("async_rst_busy", o_busy, 0);
        check("async_rst_addr", o_wb_addr, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        noack_addr = -1;
        repeat (2) @(negedge clk);
        end_checks("t6");
        push_mem(MSG_LEN);
        exp_done++;
        start_and_check();
        wait_idle("t6b_idle");
        end_checks("t6b");

        // Randomised messages, bus timing and UART back-pressure
        rand_stall = 1'b1;
        stray_ack = 1'b1;
        for (int m = 0; m < 15; m++) begin
            for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'($urandom_range(32, 126));
            busy_mode = int'($urandom_range(0, 2));
            max_ack_dly = int'($urandom_range(0, 3));
            push_mem(MSG_LEN);
            exp_done++;
            start_and_check();
            wait_idle("rand_idle");
            end_checks("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
